// File: rtl/ssd_result_display.sv
`default_nettype none
// ============================================================================
// Module   : ssd_result_display
// Purpose  : Captures a 16-bit two's-complement ALU result and its overflow
//            flag, converts the magnitude to BCD with a sequential
//            shift-add-3 engine and shows it on a 4-digit multiplexed
//            seven-segment display. All segments and enables are active-low.
// Ports    : clk      - system clock, rising edge
//            rst_n    - asynchronous active-low reset
//            result   - value to display (two's complement)
//            overflow - overflow flag paired with result
//            load     - one-cycle capture request (ignored while busy)
//            busy     - conversion in progress
//            an       - digit enables, an[3] is the leftmost digit
//            seg      - segments {g,f,e,d,c,b,a}
// Revision : 1.0 - initial release
// ============================================================================
module ssd_result_display #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] result,
    input  logic        overflow,
    input  logic        load,
    output logic        busy,
    output logic [3:0]  an,
    output logic [6:0]  seg
);

    localparam int             CNT_W     = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_R     = 7'b0101111;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               sign_q, sign_d;
    logic               ovf_q, ovf_d;
    logic [15:0]        mag_q, mag_d;
    logic [19:0]        bcd_q, bcd_d;
    logic [3:0]         bit_q, bit_d;
    logic [3:0][6:0]    dig_q, dig_d;
    logic [3:0][6:0]    w_commit;
    logic [CNT_W-1:0]   refresh_q;
    logic [1:0]         idx_q;

    function automatic logic [6:0] seg_code(input logic [3:0] n);
        logic [6:0] c;
        case (n)
            4'd0:    c = 7'b1000000;
            4'd1:    c = 7'b1111001;
            4'd2:    c = 7'b0100100;
            4'd3:    c = 7'b0110000;
            4'd4:    c = 7'b0011001;
            4'd5:    c = 7'b0010010;
            4'd6:    c = 7'b0000010;
            4'd7:    c = 7'b1111000;
            4'd8:    c = 7'b0000000;
            4'd9:    c = 7'b0010000;
            default: c = SEG_BLANK;
        endcase
        return c;
    endfunction

    // Display pattern built from the finished BCD. A negative value always
    // has a zero thousands digit when in range, so the same blanking rule
    // serves both signs for digits 2..0.
    always_comb begin
        logic [3:0] w_d0, w_d1, w_d2, w_d3, w_d4;
        logic       w_err;
        w_d0  = bcd_q[3:0];
        w_d1  = bcd_q[7:4];
        w_d2  = bcd_q[11:8];
        w_d3  = bcd_q[15:12];
        w_d4  = bcd_q[19:16];
        w_err = ovf_q | (w_d4 != 4'd0) | (sign_q & (w_d3 != 4'd0));
        w_commit = {SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_ZERO};
        if (w_err) begin
            w_commit = {SEG_E, SEG_R, SEG_R, SEG_BLANK};
        end else begin
            w_commit[0] = seg_code(w_d0);
            w_commit[1] = ((w_d3 | w_d2 | w_d1) != 4'd0) ? seg_code(w_d1) : SEG_BLANK;
            w_commit[2] = ((w_d3 | w_d2) != 4'd0) ? seg_code(w_d2) : SEG_BLANK;
            w_commit[3] = sign_q ? SEG_MINUS :
                          ((w_d3 != 4'd0) ? seg_code(w_d3) : SEG_BLANK);
        end
    end

    always_comb begin
        logic [19:0] w_adj;
        state_d = state_q;
        sign_d  = sign_q;
        ovf_d   = ovf_q;
        mag_d   = mag_q;
        bcd_d   = bcd_q;
        bit_d   = bit_q;
        dig_d   = dig_q;
        w_adj   = bcd_q;
        case (state_q)
            IDLE: begin
                if (load) begin
                    state_d = CONV;
                    sign_d  = result[15];
                    mag_d   = result[15] ? (~result + 16'd1) : result;
                    ovf_d   = overflow;
                    bcd_d   = '0;
                    bit_d   = '0;
                end
            end
            CONV: begin
                // Add 3 to any BCD digit >= 5 before shifting in the next bit.
                for (int i = 0; i < 5; i++) begin
                    if (bcd_q[4*i +: 4] >= 4'd5) begin
                        w_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
                    end
                end
                bcd_d = (w_adj << 1) | {19'd0, mag_q[15]};
                mag_d = mag_q << 1;
                bit_d = bit_q + 4'd1;
                if (bit_q == 4'd15) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                state_d = IDLE;
                dig_d   = w_commit;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sign_q  <= 1'b0;
            ovf_q   <= 1'b0;
            mag_q   <= '0;
            bcd_q   <= '0;
            bit_q   <= '0;
            dig_q   <= {SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_ZERO};
        end else begin
            state_q <= state_d;
            sign_q  <= sign_d;
            ovf_q   <= ovf_d;
            mag_q   <= mag_d;
            bcd_q   <= bcd_d;
            bit_q   <= bit_d;
            dig_q   <= dig_d;
        end
    end

    // Scan timing runs free of the conversion FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refresh_q <= '0;
            idx_q     <= 2'd0;
        end else if (refresh_q == CNT_MAX) begin
            refresh_q <= '0;
            idx_q     <= idx_q + 2'd1;
        end else begin
            refresh_q <= refresh_q + 1'b1;
        end
    end

    assign busy = (state_q != IDLE);
    assign an   = ~(4'b0001 << idx_q);
    assign seg  = dig_q[idx_q];

endmodule
`default_nettype wire

// File: tb/tb_ssd_result_display.sv
`default_nettype none
// ============================================================================
// Module   : tb_ssd_result_display
// Purpose  : Self-checking bench for ssd_result_display with REFRESH_DIV=4.
//            Directed and random captures are compared against an
//            arithmetic model of the expected display contents and scan.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ssd_result_display;

    localparam int DIV = 4;

    localparam logic [6:0] S_BLANK = 7'b1111111;
    localparam logic [6:0] S_MINUS = 7'b0111111;
    localparam logic [6:0] S_E     = 7'b0000110;
    localparam logic [6:0] S_R     = 7'b0101111;
    localparam logic [27:0] RESET_DISP = {S_BLANK, S_BLANK, S_BLANK, 7'b1000000};

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic [15:0] result   = '0;
    logic        overflow = 1'b0;
    logic        load     = 1'b0;
    logic        busy;
    logic [3:0]  an;
    logic [6:0]  seg;

    int          tests = 0;
    int          fails = 0;
    int          cyc;
    logic [27:0] exp_disp = RESET_DISP;
    logic [6:0]  segtab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000};

    ssd_result_display #(.REFRESH_DIV(DIV)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .result   (result),
        .overflow (overflow),
        .load     (load),
        .busy     (busy),
        .an       (an),
        .seg      (seg)
    );

    always #5 clk = ~clk;

    // Clock edges seen since reset release; the scan index is a pure
    // function of this count.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    function automatic logic [27:0] model(input logic [15:0] r, input logic ov);
        int v;
        int m;
        logic [3:0][6:0] d;
        v = int'($signed(r));
        if (ov || v > 9999 || v < -999) return {S_E, S_R, S_R, S_BLANK};
        m = (v < 0) ? -v : v;
        d[0] = segtab[m % 10];
        d[1] = (m >= 10)   ? segtab[(m / 10) % 10]  : S_BLANK;
        d[2] = (m >= 100)  ? segtab[(m / 100) % 10] : S_BLANK;
        d[3] = (v < 0) ? S_MINUS : ((m >= 1000) ? segtab[m / 1000] : S_BLANK);
        return d;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic scan_check();
        int idx;
        idx = (cyc / DIV) % 4;
        chk("an", {28'd0, an}, {28'd0, ~(4'b0001 << idx)});
        chk("seg", {25'd0, seg}, {25'd0, exp_disp[idx*7 +: 7]});
    endtask

    // Issue a load and follow it for 18 samples; busy must be high for the
    // 17 samples after the load edge and the display must change only at
    // the 18th. inj >= 0 fires a stray load (result=3) at that sample.
    task automatic run_load(input logic [15:0] r, input logic ov, input int inj);
        logic [27:0] newd;
        @(negedge clk);
        result = r; overflow = ov; load = 1'b1;
        newd = model(r, ov);
        for (int k = 0; k <= 17; k++) begin
            @(negedge clk);
            if (k == inj) begin
                load = 1'b1; result = 16'd3; overflow = 1'b0;
            end else begin
                load = 1'b0;
            end
            chk("busy", {31'd0, busy}, {31'd0, (k < 17)});
            if (k == 17) exp_disp = newd;
            scan_check();
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("idle_busy", {31'd0, busy}, 32'd0);
            scan_check();
        end
    endtask

    initial begin
        int          sel;
        logic [15:0] r;
        int          v;

        // Reset state
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk);
        chk("rst_an", {28'd0, an}, 32'h0000000E);
        chk("rst_seg", {25'd0, seg}, {25'd0, 7'b1000000});
        rst_n = 1'b1;

        // Free-running scan through two full rotations
        for (int k = 0; k < 34; k++) begin
            @(negedge clk);
            scan_check();
        end

        // Directed cases
        run_load(16'd49, 1'b0, -1);
        run_load(16'hFFF9, 1'b0, -1);
        run_load(16'd5, 1'b1, -1);
        run_load(16'd0, 1'b0, -1);
        run_load(16'd12345, 1'b0, -1);
        run_load(16'd9999, 1'b0, -1);
        run_load(16'h8000, 1'b0, -1);
        run_load(16'd10000, 1'b0, -1);
        run_load(16'hFC19, 1'b0, -1);   // -999
        run_load(16'hFC18, 1'b0, -1);   // -1000
        run_load(16'd786, 1'b0, 5);     // stray load during conversion

        // Random captures
        for (int n = 0; n < 30; n++) begin
            sel = $urandom_range(0, 3);
            case (sel)
                0: r = 16'($urandom_range(0, 9999));
                1: begin v = -int'($urandom_range(1, 999)); r = v[15:0]; end
                default: r = 16'($urandom);
            endcase
            run_load(r, (sel == 3) ? 1'($urandom_range(0, 1)) : 1'b0,
                     ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : -1);
        end

        // Reset in the middle of a conversion
        @(negedge clk);
        result = 16'd4321; overflow = 1'b0; load = 1'b1;
        for (int k = 0; k <= 8; k++) begin
            @(negedge clk);
            load = 1'b0;
        end
        chk("conv_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_an", {28'd0, an}, 32'h0000000E);
        chk("arst_seg", {25'd0, seg}, {25'd0, 7'b1000000});
        exp_disp = RESET_DISP;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            chk("post_rst_busy", {31'd0, busy}, 32'd0);
            scan_check();
        end

        // Display still works after the aborted conversion
        run_load(16'd321, 1'b0, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
